// File: rtl/conv_a1_ofm_collector_pkg.sv
// rtl/conv_a1_ofm_collector_pkg.sv - shared defaults, FSM states and width helper for the A1 OFM collector
package conv_a1_ofm_collector_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_IFM_SIZE          = 32;
    localparam int DEF_KERNAL_SIZE       = 5;
    localparam int DEF_NUMBER_OF_FILTERS = 6;
    localparam int DEF_NUMBER_OF_UNITS   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of the unit sum: one guard bit per doubling of the unit count plus a sign guard.
    function automatic int sum_width(input int data_width, input int n_units);
        return data_width + $clog2(n_units) + 1;
    endfunction

endpackage

// File: rtl/conv_a1_ofm_collector_ofm_sum_sat.sv
// rtl/conv_a1_ofm_collector_ofm_sum_sat.sv - widened N-input unit sum, bias add and saturation to word range
module conv_a1_ofm_collector_ofm_sum_sat #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUMBER_OF_UNITS = 3,
    parameter int SUM_WIDTH       = 35
) (
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] units_data_in,
    output logic [SUM_WIDTH-1:0]                  sum_out,
    input  logic [SUM_WIDTH-1:0]                  sum_in,
    input  logic [DATA_WIDTH-1:0]                 bias_in,
    output logic [DATA_WIDTH-1:0]                 sat_out
);

    localparam int EXT_W = SUM_WIDTH - DATA_WIDTH;

    logic [SUM_WIDTH:0]              biased;
    logic [SUM_WIDTH-DATA_WIDTH+1:0] top_bits;

    // Sign-extend every unit word and accumulate; the guard bits make overflow impossible here.
    always_comb begin
        sum_out = '0;
        for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
            sum_out = sum_out + {{EXT_W{units_data_in[k*DATA_WIDTH+DATA_WIDTH-1]}},
                                 units_data_in[k*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Add the bias one bit wider, then clamp when the bits above the word sign disagree.
    always_comb begin
        biased   = {sum_in[SUM_WIDTH-1], sum_in}
                 + {{(EXT_W+1){bias_in[DATA_WIDTH-1]}}, bias_in};
        top_bits = biased[SUM_WIDTH:DATA_WIDTH-1];
        if (top_bits == '0 || top_bits == '1) begin
            sat_out = biased[DATA_WIDTH-1:0];
        end else if (biased[SUM_WIDTH]) begin
            sat_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/conv_a1_ofm_collector.sv
// rtl/conv_a1_ofm_collector.sv - sums conv unit results, adds bias, applies ReLU and writes the A2 IFM memory
module conv_a1_ofm_collector
    import conv_a1_ofm_collector_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int IFM_SIZE          = DEF_IFM_SIZE,
    parameter int KERNAL_SIZE       = DEF_KERNAL_SIZE,
    parameter int NUMBER_OF_FILTERS = DEF_NUMBER_OF_FILTERS,
    parameter int NUMBER_OF_UNITS   = DEF_NUMBER_OF_UNITS,
    parameter int IFM_SIZE_NEXT     = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_OFM  = $clog2(NUMBER_OF_FILTERS*IFM_SIZE_NEXT*IFM_SIZE_NEXT),
    parameter int ADDRESS_SIZE_BIAS = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [DATA_WIDTH-1:0]                 riscv_data,
    input  logic                                  bias_write_enable,
    input  logic [ADDRESS_SIZE_BIAS-1:0]          bias_address,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] units_data_in,
    input  logic                                  in_valid,
    output logic                                  ofm_write_enable,
    output logic [ADDRESS_SIZE_OFM-1:0]           ofm_address,
    output logic [DATA_WIDTH-1:0]                 ofm_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overrun_error
);

    localparam int PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int PIX_W  = $clog2(PIXELS);
    localparam int FLT_W  = ADDRESS_SIZE_BIAS;
    localparam int SUM_W  = sum_width(DATA_WIDTH, NUMBER_OF_UNITS);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(NUMBER_OF_FILTERS - 1);

    state_t                      state_q, state_d;
    logic [PIX_W-1:0]            pixel_q, pixel_d;
    logic [FLT_W-1:0]            filter_q, filter_d;
    logic [ADDRESS_SIZE_OFM-1:0] addr_q, addr_d;
    logic                        done_q, done_d;
    logic                        overrun_q, overrun_d;
    logic                        accept;

    logic [DATA_WIDTH-1:0]       bias_q [NUMBER_OF_FILTERS];
    logic [DATA_WIDTH-1:0]       bias_d [NUMBER_OF_FILTERS];

    logic                        s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0]            s1_sum_q, s1_sum_d;
    logic [FLT_W-1:0]            s1_filter_q, s1_filter_d;
    logic [ADDRESS_SIZE_OFM-1:0] s1_addr_q, s1_addr_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]       s2_data_q, s2_data_d;
    logic [ADDRESS_SIZE_OFM-1:0] s2_addr_q, s2_addr_d;
    logic                        we_q, we_d;
    logic [ADDRESS_SIZE_OFM-1:0] ofm_addr_q, ofm_addr_d;
    logic [DATA_WIDTH-1:0]       ofm_data_q, ofm_data_d;

    logic [SUM_W-1:0]            sum_comb;
    logic [DATA_WIDTH-1:0]       sat_comb;

    conv_a1_ofm_collector_ofm_sum_sat #(
        .DATA_WIDTH      (DATA_WIDTH),
        .NUMBER_OF_UNITS (NUMBER_OF_UNITS),
        .SUM_WIDTH       (SUM_W)
    ) u_sum_sat (
        .units_data_in (units_data_in),
        .sum_out       (sum_comb),
        .sum_in        (s1_sum_q),
        .bias_in       (bias_q[s1_filter_q]),
        .sat_out       (sat_comb)
    );

    // Frame sequencing: pixel/filter/address counters advance only on accepted pixels.
    always_comb begin
        state_d   = state_q;
        pixel_d   = pixel_q;
        filter_d  = filter_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        overrun_d = overrun_q | (in_valid & (state_q != ST_RUN));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    pixel_d  = '0;
                    filter_d = '0;
                    addr_d   = '0;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (pixel_q == PIX_LAST) begin
                        pixel_d = '0;
                        if (filter_q == FLT_LAST) begin
                            state_d = ST_DRAIN;
                        end else begin
                            filter_d = filter_q + 1'b1;
                        end
                    end else begin
                        pixel_d = pixel_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bias table is only writable while idle so a frame always sees a stable set.
    always_comb begin
        bias_d = bias_q;
        if (bias_write_enable && state_q == ST_IDLE && bias_address <= FLT_LAST) begin
            bias_d[bias_address] = riscv_data;
        end
    end

    // Three-stage datapath: sum, bias+saturate, ReLU; address rides along with the data.
    always_comb begin
        s1_valid_d  = accept;
        s1_sum_d    = accept ? sum_comb : s1_sum_q;
        s1_filter_d = accept ? filter_q : s1_filter_q;
        s1_addr_d   = accept ? addr_q : s1_addr_q;
        s2_valid_d  = s1_valid_q;
        s2_data_d   = s1_valid_q ? sat_comb : s2_data_q;
        s2_addr_d   = s1_valid_q ? s1_addr_q : s2_addr_q;
        we_d        = s2_valid_q;
        ofm_addr_d  = s2_valid_q ? s2_addr_q : ofm_addr_q;
        ofm_data_d  = ofm_data_q;
        if (s2_valid_q) begin
            ofm_data_d = s2_data_q[DATA_WIDTH-1] ? '0 : s2_data_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pixel_q   <= '0;
            filter_q  <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            bias_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pixel_q   <= pixel_d;
            filter_q  <= filter_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            bias_q    <= bias_d;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_filter_q <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_addr_q   <= '0;
            we_q        <= 1'b0;
            ofm_addr_q  <= '0;
            ofm_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_filter_q <= s1_filter_d;
            s1_addr_q   <= s1_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_addr_q   <= s2_addr_d;
            we_q        <= we_d;
            ofm_addr_q  <= ofm_addr_d;
            ofm_data_q  <= ofm_data_d;
        end
    end

    assign ofm_write_enable = we_q;
    assign ofm_address      = ofm_addr_q;
    assign ofm_data         = ofm_data_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign overrun_error    = overrun_q;

endmodule

// File: tb/tb_conv_a1_ofm_collector.sv
// tb/tb_conv_a1_ofm_collector.sv - self-checking bench for the A1 OFM collector
module tb_conv_a1_ofm_collector;

    localparam int NF    = 6;
    localparam int PIX   = 28 * 28;
    localparam int TOTAL = NF * PIX;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] riscv_data = '0;
    logic        bias_write_enable = 1'b0;
    logic [2:0]  bias_address = '0;
    logic [95:0] units_data_in = '0;
    logic        in_valid = 1'b0;
    logic        ofm_write_enable;
    logic [12:0] ofm_address;
    logic [31:0] ofm_data;
    logic        busy;
    logic        done;
    logic        overrun_error;

    conv_a1_ofm_collector dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .riscv_data        (riscv_data),
        .bias_write_enable (bias_write_enable),
        .bias_address      (bias_address),
        .units_data_in     (units_data_in),
        .in_valid          (in_valid),
        .ofm_write_enable  (ofm_write_enable),
        .ofm_address       (ofm_address),
        .ofm_data          (ofm_data),
        .busy              (busy),
        .done              (done),
        .overrun_error     (overrun_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] bias_m [NF];
    bit          running = 0;
    int          idx = 0;
    int          busy_from = -1;
    int          done_cyc = -1;
    int          ovr_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_pixel(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] bias);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c)) + longint'($signed(bias));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        if (s < 0) s = 0;
        return s[31:0];
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        if ($urandom_range(0, 15) == 0) v = $urandom;
        else v = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
        return v;
    endfunction

    // Compare DUT outputs against the model once per cycle, away from the active edge.
    always @(negedge clk) begin : compare
        bit exp_we;
        exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("ofm_write_enable", ofm_write_enable, exp_we);
        if (exp_we) begin
            chk("ofm_address", ofm_address, exp_q[0].addr);
            chk("ofm_data", ofm_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        chk("done", done, cyc == done_cyc);
        chk("busy", busy, busy_from >= 0 && cyc >= busy_from && (done_cyc < 0 || cyc < done_cyc));
        chk("overrun_error", overrun_error, ovr_cyc >= 0 && cyc >= ovr_cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        running   = 0;
        idx       = 0;
        busy_from = -1;
        done_cyc  = -1;
        ovr_cyc   = -1;
        for (int i = 0; i < NF; i++) bias_m[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic bias_write(input int a, input logic [31:0] d, input bit taken);
        bias_address      = 3'(a);
        riscv_data        = d;
        bias_write_enable = 1'b1;
        if (taken && a < NF) bias_m[a] = d;
        step();
        bias_write_enable = 1'b0;
    endtask

    task automatic start_frame();
        start     = 1'b1;
        running   = 1;
        idx       = 0;
        busy_from = cyc + 1;
        done_cyc  = -1;
        step();
        start = 1'b0;
    endtask

    task automatic drive_pixel(input logic [31:0] u0, input logic [31:0] u1, input logic [31:0] u2);
        units_data_in = {u2, u1, u0};
        in_valid      = 1'b1;
        if (running) begin
            exp_q.push_back('{cyc + 3, idx, model_pixel(u0, u1, u2, bias_m[idx / PIX])});
            idx++;
            if (idx == TOTAL) begin
                running  = 0;
                done_cyc = cyc + 4;
            end
        end else if (ovr_cyc < 0) begin
            ovr_cyc = cyc + 1;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string name, input int addr, input logic [31:0] data);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (ofm_write_enable) begin
                seen = 1;
                chk({name, "_addr"}, ofm_address, addr);
                chk({name, "_data"}, ofm_data, data);
            end
        end
        chk({name, "_seen"}, seen, 1);
        step();
    endtask

    initial begin
        bit seen;
        model_clear();
        step();
        step();
        reset = 1'b1;
        repeat (3) step();

        // reset while idle
        do_reset();
        chk("rst_we", ofm_write_enable, 0);
        chk("rst_addr", ofm_address, 0);
        chk("rst_data", ofm_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun_error, 0);

        // bias reads back 0; negative sum clamps to 0 but still writes
        start_frame();
        chk("busy_after_start", busy, 1);
        drive_pixel(32'h0, 32'h0, 32'h0);
        expect_write("zero_bias", 0, 32'h0000_0000);
        drive_pixel(32'hFFFE_0000, 32'h0, 32'h0);
        expect_write("relu", 1, 32'h0000_0000);

        // 2 + 3 - 1 + 1 = 5.0
        do_reset();
        bias_write(0, 32'h0001_0000, 1);
        start_frame();
        drive_pixel(32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000);
        expect_write("sum_bias", 0, 32'h0005_0000);

        // positive and negative saturation
        do_reset();
        bias_write(0, 32'h7FFF_0000, 1);
        start_frame();
        drive_pixel(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
        expect_write("sat_pos", 0, 32'h7FFF_FFFF);
        drive_pixel(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        expect_write("sat_neg", 1, 32'h0000_0000);

        // full frame with random gaps, ignored start and ignored bias write mid-frame
        do_reset();
        for (int f = 0; f < NF; f++) bias_write(f, $urandom_range(0, 32'h0004_0000) - 32'h0002_0000, 1);
        bias_write(6, 32'h1234_5678, 1);
        start_frame();
        for (int i = 0; i < TOTAL; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
            if (i == 1000) begin
                start = 1'b1;
                step();
                start = 1'b0;
                bias_write(5, 32'h3FFF_0000, 0);
            end
            drive_pixel(rand_word(), rand_word(), rand_word());
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        step();
        drive_pixel(32'h0001_0000, 32'h0, 32'h0);
        step();
        chk("overrun_sticky", overrun_error, 1);
        chk("idle_after_frame", busy, 0);

        // reset with three pixels in flight, then restart at address 0
        do_reset();
        start_frame();
        for (int i = 0; i < 103; i++) drive_pixel(32'(i) << 16, 32'h0, 32'h0);
        do_reset();
        repeat (5) step();
        start_frame();
        drive_pixel(32'h0001_0000, 32'h0, 32'h0);
        expect_write("restart", 0, 32'h0001_0000);

        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
